// File: rtl/system_pio_in_debounced.sv
// Avalon-MM input PIO: per-bit synchroniser, debounce filter, edge capture
// with write-1-to-clear, and a maskable level interrupt.
module system_pio_in_debounced #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             unused_wdata;

    // Upper writedata bits beyond WIDTH are intentionally ignored.
    assign unused_wdata = ^writedata;
    assign sync         = sync_q[SYNC_STAGES-1];
    assign wr_en        = chipselect & ~write_n;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Any cycle where sync agrees with deb restarts qualification.
    always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync[b] == deb_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                deb_d[b] = sync[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        case (EDGE_MODE)
            0:       edge_evt = deb_d & ~deb_q;
            1:       edge_evt = ~deb_d & deb_q;
            default: edge_evt = deb_d ^ deb_q;
        endcase
        w1c    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // A new event overrides a simultaneous clear of the same bit.
        ecap_d = (ecap_q & ~w1c) | edge_evt;
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        irq_d  = |(ecap_q & mask_q);
        case (address)
            2'd0:    readdata_d = 32'(deb_q);
            2'd1:    readdata_d = 32'(sync);
            2'd2:    readdata_d = 32'(mask_q);
            default: readdata_d = 32'(ecap_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
            deb_q      <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            deb_q      <= deb_d;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_system_pio_in_debounced.sv
// Self-checking bench: rising-edge and falling-edge builds side by side,
// directed sequences, a register-access table, and randomized model checks.
module tb_system_pio_in_debounced;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    system_pio_in_debounced #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

    system_pio_in_debounced #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: levels qualified by run length of disagreement.
    logic [W-1:0] m_hist [$];
    int unsigned  m_run [W];
    logic [W-1:0] m_deb, m_mask, m_ec0, m_ec1;
    logic [31:0]  e_rd0, e_rd1;
    logic         e_irq0, e_irq1;

    function automatic logic [31:0] reg_view(input logic [1:0] a, input logic [W-1:0] ec);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd1:    return 32'(m_hist[0]);
            2'd2:    return 32'(m_mask);
            default: return 32'(ec);
        endcase
    endfunction

    task automatic model_step();
        logic [W-1:0] sy, ev_r, ev_f, clr;
        logic wr;
        if (!reset_n) begin
            m_hist = {};
            for (int i = 0; i < SS; i++) m_hist.push_back('0);
            for (int b = 0; b < W; b++) m_run[b] = 0;
            m_deb = '0; m_mask = '0; m_ec0 = '0; m_ec1 = '0;
            e_rd0 = '0; e_rd1 = '0; e_irq0 = 1'b0; e_irq1 = 1'b0;
            return;
        end
        sy     = m_hist[0];
        e_rd0  = reg_view(address, m_ec0);
        e_rd1  = reg_view(address, m_ec1);
        e_irq0 = |(m_ec0 & m_mask);
        e_irq1 = |(m_ec1 & m_mask);
        ev_r = '0; ev_f = '0;
        for (int b = 0; b < W; b++) begin
            if (sy[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DC) begin
                    if (sy[b]) ev_r[b] = 1'b1; else ev_f[b] = 1'b1;
                    m_deb[b] = sy[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        wr    = chipselect && !write_n;
        clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ec0 = (m_ec0 & ~clr) | ev_r;
        m_ec1 = (m_ec1 & ~clr) | ev_f;
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        m_hist.push_back(in_port);
        void'(m_hist.pop_front());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_rd0", rd0, e_rd0);
        chk("model_irq0", {31'b0, irq0}, {31'b0, e_irq0});
        chk("model_rd1", rd1, e_rd1);
        chk("model_irq1", {31'b0, irq1}, {31'b0, e_irq1});
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0; write_n = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        cyc();
    endtask

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t tbl [16];

    initial begin
        tbl[0]  = '{2'd3, 1'b0, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[1]  = '{2'd3, 1'b1, 1'b0, 32'hF,        32'hF, 1'b0};
        tbl[2]  = '{2'd3, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[3]  = '{2'd2, 1'b1, 1'b0, 32'h3,        32'h0, 1'b0};
        tbl[4]  = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h3, 1'b0};
        tbl[5]  = '{2'd0, 1'b1, 1'b0, 32'h0,        32'hF, 1'b0};
        tbl[6]  = '{2'd1, 1'b1, 1'b0, 32'h0,        32'hF, 1'b0};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[8]  = '{2'd1, 1'b0, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[9]  = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFF0, 32'h3, 1'b0};
        tbl[10] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[11] = '{2'd2, 1'b0, 1'b0, 32'hF,        32'h0, 1'b0};
        tbl[12] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[13] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0};
        tbl[14] = '{2'd2, 1'b0, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[15] = '{2'd2, 1'b1, 1'b0, 32'h1,        32'hF, 1'b0};

        reset_n = 1'b0; address = 2'd3; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'hF;

        // Reset with inputs high
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_rd", rd0, 32'h0);
            chk("reset_irq", {31'b0, irq0}, 32'h0);
        end
        reset_n = 1'b1; address = 2'd0;
        repeat (6) cyc();
        chk("post_reset_data_early", rd0, 32'h0);
        cyc();
        chk("post_reset_data", rd0, 32'hF);
        idle(3);
        rd(2'd3);
        chk("post_reset_ecap_rise", rd0, 32'hF);
        chk("post_reset_ecap_fall", rd1, 32'h0);

        // Register access table
        for (int i = 0; i < 16; i++) begin
            address = tbl[i].addr; chipselect = tbl[i].cs;
            write_n = tbl[i].wr_n; writedata = tbl[i].wdata;
            cyc();
            chk($sformatf("tbl%0d_rd", i), rd0, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), {31'b0, irq0}, {31'b0, tbl[i].exp_irq});
        end
        idle(1);

        // Clean press on bit 0 with mask=1
        in_port = 4'h0; address = 2'd0;
        idle(10);
        chk("all_low", rd0, 32'h0);
        wr(2'd3, 32'hF);
        idle(2);
        in_port = 4'h1; address = 2'd1;
        repeat (3) cyc();
        chk("press_raw", rd0, 32'h1);
        address = 2'd0;
        repeat (3) cyc();
        chk("press_data_early", rd0, 32'h0);
        chk("press_irq_early", {31'b0, irq0}, 32'h0);
        cyc();
        chk("press_data", rd0, 32'h1);
        chk("press_irq", {31'b0, irq0}, 32'h1);
        wr(2'd3, 32'h1);
        chk("w1c_irq_lag", {31'b0, irq0}, 32'h1);
        idle(1);
        chk("w1c_irq_low", {31'b0, irq0}, 32'h0);

        // Glitch on bit 1 shorter than the debounce window
        in_port = 4'h3;
        idle(3);
        in_port = 4'h1;
        idle(10);
        rd(2'd0);
        chk("glitch_data", rd0, 32'h1);
        rd(2'd3);
        chk("glitch_ecap", rd0, 32'h0);
        chk("glitch_irq", {31'b0, irq0}, 32'h0);

        // W1C colliding with a fresh bit-0 rising edge
        in_port = 4'h0;
        idle(10);
        in_port = 4'h1;
        idle(5);
        wr(2'd3, 32'h1);
        rd(2'd3);
        chk("collision_set_wins", rd0, 32'h1);

        // Masking
        wr(2'd3, 32'hF);
        in_port = 4'h3;
        idle(10);
        rd(2'd3);
        chk("mask_ecap", rd0, 32'h2);
        chk("mask_irq_off", {31'b0, irq0}, 32'h0);
        wr(2'd2, 32'h3);
        chk("mask_irq_lag", {31'b0, irq0}, 32'h0);
        idle(1);
        chk("mask_irq_on", {31'b0, irq0}, 32'h1);

        // Falling-edge build: bit 2 up then down
        wr(2'd3, 32'hF);
        in_port = 4'h7;
        idle(10);
        rd(2'd3);
        chk("mode1_rise_ignored", {31'b0, rd1[2]}, 32'h0);
        in_port = 4'h3;
        idle(10);
        rd(2'd3);
        chk("mode1_fall_captured", {31'b0, rd1[2]}, 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W-1));
            address    = 2'($urandom);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            writedata  = $urandom;
            reset_n    = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
